// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data/program memory responder.
package data_mem_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } ch_state_t;

endpackage

// File: rtl/data_mem_responder_channel.sv
// One memory channel: holds a granted consumer request, runs it against memory
// and relays the completion back until the consumer lets go.
module mem_channel
    import data_mem_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int ID_BITS   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 grant,
    input  logic                 grant_write,
    input  logic [ID_BITS-1:0]   grant_id,
    input  logic [ADDR_BITS-1:0] grant_address,
    input  logic [DATA_BITS-1:0] grant_data,
    input  logic                 cons_read_valid,
    input  logic                 cons_write_valid,
    output logic                 idle,
    output logic [ID_BITS-1:0]   cons_id,
    output logic                 read_relay,
    output logic                 write_relay,
    output logic [DATA_BITS-1:0] relay_data,
    output logic                 release_claim,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready
);

    ch_state_t            state, state_nxt;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cons_id <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant) begin
                cons_id <= grant_id;
                addr_q  <= grant_address;
                data_q  <= grant_data;
            end
            // data_q is reused: write payload on the way out, read data on the way back
            if (state == READ_WAIT && mem_read_ready)
                data_q <= mem_read_data;
        end
    end

    always_comb begin
        state_nxt       = state;
        release_claim   = 1'b0;
        mem_read_valid  = 1'b0;
        mem_write_valid = 1'b0;
        read_relay      = 1'b0;
        write_relay     = 1'b0;
        case (state)
            IDLE:
                if (grant) state_nxt = grant_write ? WRITE_WAIT : READ_WAIT;
            READ_WAIT: begin
                mem_read_valid = 1'b1;
                if (mem_read_ready) state_nxt = READ_RELAY;
            end
            WRITE_WAIT: begin
                mem_write_valid = 1'b1;
                if (mem_write_ready) state_nxt = WRITE_RELAY;
            end
            READ_RELAY: begin
                read_relay = 1'b1;
                if (!cons_read_valid) begin
                    state_nxt     = IDLE;
                    release_claim = 1'b1;
                end
            end
            WRITE_RELAY: begin
                write_relay = 1'b1;
                if (!cons_write_valid) begin
                    state_nxt     = IDLE;
                    release_claim = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign idle              = (state == IDLE);
    assign mem_read_address  = mem_read_valid  ? addr_q : '0;
    assign mem_write_address = mem_write_valid ? addr_q : '0;
    assign mem_write_data    = mem_write_valid ? data_q : '0;
    assign relay_data        = read_relay      ? data_q : '0;

endmodule

// File: rtl/data_mem_responder.sv
// Multiplexes per-consumer read/write requests onto a set of memory channels
// with per-channel round-robin arbitration and a shared claim mask.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_read_data,
    output logic [NUM_CHANNELS-1:0]                   mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                   mem_write_ready
);

    localparam int ID_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    logic [NUM_CONSUMERS-1:0] write_req, claim, claim_nxt, avail;

    logic [NUM_CHANNELS-1:0]                ch_idle, grant, grant_write;
    logic [NUM_CHANNELS-1:0]                ch_read_relay, ch_write_relay, ch_release;
    logic [NUM_CHANNELS-1:0][ID_BITS-1:0]   grant_id, ch_id, rr_ptr;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] grant_address, ch_mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] grant_data, ch_relay_data, ch_mem_write_data;
    logic [NUM_CHANNELS-1:0]                ch_mem_write_valid, ch_mem_write_ready;

    assign write_req          = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
    assign ch_mem_write_ready = (WRITE_ENABLE != 0) ? mem_write_ready : '0;

    // Channels allocate in ascending order; each grant hides that consumer from
    // the channels above it in the same cycle.
    always_comb begin
        avail         = (consumer_read_valid | write_req) & ~claim;
        grant         = '0;
        grant_write   = '0;
        grant_id      = '0;
        grant_address = '0;
        grant_data    = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (ch_idle[k]) begin
                for (int i = 0; i < NUM_CONSUMERS; i++) begin
                    if (!grant[k] && avail[(int'(rr_ptr[k]) + i) % NUM_CONSUMERS]) begin
                        grant[k]    = 1'b1;
                        grant_id[k] = ID_BITS'((int'(rr_ptr[k]) + i) % NUM_CONSUMERS);
                    end
                end
                if (grant[k]) begin
                    grant_write[k]   = !consumer_read_valid[grant_id[k]];
                    grant_address[k] = grant_write[k] ? consumer_write_address[grant_id[k]]
                                                      : consumer_read_address[grant_id[k]];
                    grant_data[k]    = consumer_write_data[grant_id[k]];
                    avail[grant_id[k]] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        claim_nxt = claim;
        for (int k = 0; k < NUM_CHANNELS; k++)
            if (ch_release[k]) claim_nxt[ch_id[k]] = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++)
            if (grant[k]) claim_nxt[grant_id[k]] = 1'b1;
    end

    // rr_ptr holds the first consumer to search, i.e. one past the last grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            claim  <= '0;
            rr_ptr <= '0;
        end else begin
            claim <= claim_nxt;
            for (int k = 0; k < NUM_CHANNELS; k++)
                if (grant[k])
                    rr_ptr[k] <= ID_BITS'((int'(grant_id[k]) + 1) % NUM_CONSUMERS);
        end
    end

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
        mem_channel #(
            .ADDR_BITS(ADDR_BITS),
            .DATA_BITS(DATA_BITS),
            .ID_BITS  (ID_BITS)
        ) u_ch (
            .clk              (clk),
            .reset            (reset),
            .grant            (grant[k]),
            .grant_write      (grant_write[k]),
            .grant_id         (grant_id[k]),
            .grant_address    (grant_address[k]),
            .grant_data       (grant_data[k]),
            .cons_read_valid  (consumer_read_valid[ch_id[k]]),
            .cons_write_valid (write_req[ch_id[k]]),
            .idle             (ch_idle[k]),
            .cons_id          (ch_id[k]),
            .read_relay       (ch_read_relay[k]),
            .write_relay      (ch_write_relay[k]),
            .relay_data       (ch_relay_data[k]),
            .release_claim    (ch_release[k]),
            .mem_read_valid   (mem_read_valid[k]),
            .mem_read_address (mem_read_address[k]),
            .mem_read_ready   (mem_read_ready[k]),
            .mem_read_data    (mem_read_data[k]),
            .mem_write_valid  (ch_mem_write_valid[k]),
            .mem_write_address(ch_mem_write_address[k]),
            .mem_write_data   (ch_mem_write_data[k]),
            .mem_write_ready  (ch_mem_write_ready[k])
        );
    end

    assign mem_write_valid   = (WRITE_ENABLE != 0) ? ch_mem_write_valid   : '0;
    assign mem_write_address = (WRITE_ENABLE != 0) ? ch_mem_write_address : '0;
    assign mem_write_data    = (WRITE_ENABLE != 0) ? ch_mem_write_data    : '0;

    // A consumer is held by at most one channel, so OR-merging is exact.
    always_comb begin
        consumer_read_ready  = '0;
        consumer_read_data   = '0;
        consumer_write_ready = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (ch_read_relay[k]) begin
                consumer_read_ready[ch_id[k]] = 1'b1;
                consumer_read_data[ch_id[k]]  = ch_relay_data[k];
            end
            if (ch_write_relay[k] && WRITE_ENABLE != 0)
                consumer_write_ready[ch_id[k]] = 1'b1;
        end
    end

endmodule
